alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, A (core datapath) and B (auxiliary sequencer), on a round-robin basis. It issues at most one ALU operation per cycle and returns a registered result with flags one cycle later. It instantiates the ALU internally with SC_in tied to 0, and owns the ALU's opcode and operand inputs.

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between requesters A and B; result 1 cycle after grant, no backpressure.
// Optional ALU_ARB_LOCK_EN adds LockA/LockB so a grantee can hold the ALU across consecutive cycles.

package definitions_pkg;
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SRL = 3'd1;
  localparam logic [2:0] XOR = 3'd2;
  localparam logic [2:0] AND = 3'd3;
endpackage

module alu
  import definitions_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 3
) (
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  input  logic           SC_in,
  output logic [W-1:0]   Out,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd
);
  logic legal;

  always_comb begin
    Out   = '0;
    legal = 1'b1;
    case (OP)
      Ops'(ADD): Out = InputA + InputB + {{(W-1){1'b0}}, SC_in};
      Ops'(SRL): Out = InputA >> InputB;
      Ops'(XOR): Out = InputA ^ InputB;
      Ops'(AND): Out = InputA & InputB;
      default: begin
        Out   = 'x;
        legal = 1'b0;
      end
    endcase
  end

  // Zero deliberately tracks a nonzero operand A, not a zero result.
  assign Zero   = legal & (|InputA);
  assign Parity = legal & (^Out);
  assign Odd    = legal & Out[0];
endmodule

module alu_arbiter
  import definitions_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           ReqA,
  input  logic           ReqB,
  input  logic [Ops-1:0] OpA,
  input  logic [Ops-1:0] OpB,
  input  logic [W-1:0]   InA0,
  input  logic [W-1:0]   InA1,
  input  logic [W-1:0]   InB0,
  input  logic [W-1:0]   InB1,
`ifdef ALU_ARB_LOCK_EN
  input  logic           LockA,
  input  logic           LockB,
`endif
  output logic           GntA,
  output logic           GntB,
  output logic [W-1:0]   Result,
  output logic           ZeroF,
  output logic           ParityF,
  output logic           OddF,
  output logic           ValidA,
  output logic           ValidB,
  output logic           Busy
);
  logic           prio;
  logic           gnt_a, gnt_b;
  logic           hold_a, hold_b;
  logic [Ops-1:0] op_sel;
  logic [W-1:0]   a_sel, b_sel;
  logic [W-1:0]   alu_out;
  logic           alu_zero, alu_parity, alu_odd;

`ifdef ALU_ARB_LOCK_EN
  logic lock_a_q, lock_b_q;

  // A lock only carries over from a cycle in which that side actually held the grant.
  assign hold_a = lock_a_q & ReqA & LockA;
  assign hold_b = lock_b_q & ReqB & LockB;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      lock_a_q <= 1'b0;
      lock_b_q <= 1'b0;
    end else begin
      lock_a_q <= gnt_a & LockA;
      lock_b_q <= gnt_b & LockB;
    end
  end
`else
  assign hold_a = 1'b0;
  assign hold_b = 1'b0;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (Reset) begin
      if (hold_a)                      gnt_a = 1'b1;
      else if (hold_b)                 gnt_b = 1'b1;
      else if (ReqA && (!ReqB || !prio)) gnt_a = 1'b1;
      else if (ReqB)                   gnt_b = 1'b1;
    end
  end

  assign GntA = gnt_a;
  assign GntB = gnt_b;

  always_comb begin
    op_sel = Ops'(ADD);
    a_sel  = '0;
    b_sel  = '0;
    if (gnt_a) begin
      op_sel = OpA;
      a_sel  = InA0;
      b_sel  = InA1;
    end else if (gnt_b) begin
      op_sel = OpB;
      a_sel  = InB0;
      b_sel  = InB1;
    end
  end

  alu #(.W(W), .Ops(Ops)) u_alu (
    .InputA (a_sel),
    .InputB (b_sel),
    .OP     (op_sel),
    .SC_in  (1'b0),
    .Out    (alu_out),
    .Zero   (alu_zero),
    .Parity (alu_parity),
    .Odd    (alu_odd)
  );

  // During a lock the grantee keeps winning, so prio naturally stays pointed at the other side.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prio    <= 1'b0;
      Result  <= '0;
      ZeroF   <= 1'b0;
      ParityF <= 1'b0;
      OddF    <= 1'b0;
      ValidA  <= 1'b0;
      ValidB  <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      ValidA <= gnt_a;
      ValidB <= gnt_b;
      Busy   <= gnt_a | gnt_b;
      if (gnt_a)      prio <= 1'b1;
      else if (gnt_b) prio <= 1'b0;
      if (gnt_a || gnt_b) begin
        Result  <= alu_out;
        ZeroF   <= alu_zero;
        ParityF <= alu_parity;
        OddF    <= alu_odd;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, idle hold, back-to-back, reset mid-op, lock.
module tb_alu_arbiter;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ReqA = 1'b0, ReqB = 1'b0;
  logic [2:0] OpA = 3'd0, OpB = 3'd0;
  logic [7:0] InA0 = 8'h00, InA1 = 8'h00, InB0 = 8'h00, InB1 = 8'h00;
`ifdef ALU_ARB_LOCK_EN
  logic       LockA = 1'b0, LockB = 1'b0;
`endif
  logic       GntA, GntB;
  logic [7:0] Result;
  logic       ZeroF, ParityF, OddF, ValidA, ValidB, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {Result, ZeroF, ParityF, OddF, ValidA, ValidB, Busy}
  logic [13:0] obs;
  assign obs = {Result, ZeroF, ParityF, OddF, ValidA, ValidB, Busy};

  alu_arbiter #(.W(8), .Ops(3)) dut (
    .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB),
    .OpA(OpA), .OpB(OpB), .InA0(InA0), .InA1(InA1), .InB0(InB0), .InB1(InB1),
`ifdef ALU_ARB_LOCK_EN
    .LockA(LockA), .LockB(LockB),
`endif
    .GntA(GntA), .GntB(GntB), .Result(Result), .ZeroF(ZeroF), .ParityF(ParityF),
    .OddF(OddF), .ValidA(ValidA), .ValidB(ValidB), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_b_and();
    OpB = OP_AND; InB0 = 8'h3C; InB1 = 8'h0F;
  endtask

  task automatic test_reset();
    Reset = 1'b0; ReqA = 1'b1; ReqB = 1'b1;
    OpA = OP_ADD; InA0 = 8'h05; InA1 = 8'h03;
    set_b_and();
    tick(); tick();
    n_checks++;
    if ({GntA, GntB} !== 2'b00) begin
      n_fail++; $display("FAIL rst_gnt: got %b expected 00", {GntA, GntB});
    end
    n_checks++;
    if (obs !== 14'h0000) begin
      n_fail++; $display("FAIL rst_state: got %h expected 0000", obs);
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_gnt: got %b expected 10", {GntA, GntB});
    end
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    n_checks++;
    if (obs !== {8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_first_result: got %h expected %h", obs, {8'h08, 6'b110101});
    end
    tick();
    n_checks++;
    if (obs !== {8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_idle: got %h expected %h", obs, {8'h08, 6'b110000});
    end
  endtask

  task automatic test_idle_hold();
    ReqB = 1'b1; set_b_and();
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b01) begin
      n_fail++; $display("FAIL idle_b_gnt: got %b expected 01", {GntA, GntB});
    end
    tick();
    ReqB = 1'b0;
    n_checks++;
    if (obs !== {8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL idle_b_result: got %h expected %h", obs, {8'h0C, 6'b100011});
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({GntA, GntB} !== 2'b00) begin
        n_fail++; $display("FAIL idle_gnt[%0d]: got %b expected 00", i, {GntA, GntB});
      end
      tick();
      n_checks++;
      if (obs !== {8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL idle_hold[%0d]: got %h expected %h", i, obs, {8'h0C, 6'b100000});
      end
    end
  endtask

  // Prio is 0 on entry (last grant went to B), so the sequence starts with A.
  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [13:0] exp_obs;
    ReqA = 1'b1; ReqB = 1'b1;
    OpA = OP_XOR; InA0 = 8'hF0; InA1 = 8'h0F;
    set_b_and();
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_obs = (i % 2 == 0) ? {8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}
                             : {8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      #1;
      n_checks++;
      if ({GntA, GntB} !== exp_gnt) begin
        n_fail++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, {GntA, GntB}, exp_gnt);
      end
      tick();
      if (i == 3) begin
        ReqA = 1'b0; ReqB = 1'b0;
      end
      n_checks++;
      if (obs !== exp_obs) begin
        n_fail++; $display("FAIL cont_result[%0d]: got %h expected %h", i, obs, exp_obs);
      end
    end
  endtask

  task automatic test_single_op();
    ReqA = 1'b1; OpA = OP_ADD; InA0 = 8'h05; InA1 = 8'h03;
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++; $display("FAIL single_gnt: got %b expected 10", {GntA, GntB});
    end
    tick();
    ReqA = 1'b0;
    n_checks++;
    if (obs !== {8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_result: got %h expected %h", obs, {8'h08, 6'b110101});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3];
    logic [7:0]  a0 [3];
    logic [7:0]  a1 [3];
    logic [13:0] exp [3];
    ops[0] = OP_ADD; a0[0] = 8'h01; a1[0] = 8'h01; exp[0] = {8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ops[1] = OP_SRL; a0[1] = 8'h80; a1[1] = 8'h01; exp[1] = {8'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ops[2] = OP_XOR; a0[2] = 8'hAA; a1[2] = 8'h55; exp[2] = {8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      ReqA = 1'b1; OpA = ops[i]; InA0 = a0[i]; InA1 = a1[i];
      #1;
      n_checks++;
      if ({GntA, GntB} !== 2'b10) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected 10", i, {GntA, GntB});
      end
      tick();
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs, exp[i]);
      end
    end
    ReqB = 1'b1; set_b_and();
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_prio: got %b expected 01", {GntA, GntB});
    end
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    n_checks++;
    if (obs !== {8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL b2b_b_result: got %h expected %h", obs, {8'h0C, 6'b100011});
    end
  endtask

  task automatic test_reset_mid();
    ReqA = 1'b1; OpA = OP_SRL; InA0 = 8'h80; InA1 = 8'h01;
    Reset = 1'b0;
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b00) begin
      n_fail++; $display("FAIL mid_gnt: got %b expected 00", {GntA, GntB});
    end
    tick();
    Reset = 1'b1; ReqA = 1'b0;
    n_checks++;
    if (obs !== 14'h0000) begin
      n_fail++; $display("FAIL mid_discard: got %h expected 0000", obs);
    end
    tick();
    n_checks++;
    if (obs !== 14'h0000) begin
      n_fail++; $display("FAIL mid_no_valid: got %h expected 0000", obs);
    end
    ReqA = 1'b1; OpA = OP_ADD; InA0 = 8'h05; InA1 = 8'h03;
    ReqB = 1'b1;
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++; $display("FAIL mid_resume_gnt: got %b expected 10", {GntA, GntB});
    end
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    n_checks++;
    if (obs !== {8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL mid_resume_result: got %h expected %h", obs, {8'h08, 6'b110101});
    end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    Reset = 1'b0;
    tick();
    Reset = 1'b1; ReqA = 1'b1; ReqB = 1'b1; LockA = 1'b1; LockB = 1'b0;
    OpA = OP_ADD; InA0 = 8'h05; InA1 = 8'h03;
    set_b_and();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({GntA, GntB} !== 2'b10) begin
        n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected 10", i, {GntA, GntB});
      end
      tick();
    end
    LockA = 1'b0;
    #1;
    n_checks++;
    if ({GntA, GntB} !== 2'b01) begin
      n_fail++; $display("FAIL lock_release: got %b expected 01", {GntA, GntB});
    end
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_hold();
    test_contention();
    test_single_op();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
